dpa_scale_cont: RTL and testbench

DPA_SCALE_CONT -- requirements
Module: dpa_scale_cont

---
 rtl/dpa_scale_cont.sv | 214 +++++++++++++++++++++
 tb/tb_dpa_scale_cont.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpa_scale_cont.sv
// Photo-frame scaler: reads a header and photo table from image memory, then copies,
// 2x upscales or 2x box-downscales one photo per display period into the framebuffer.
module dpa_scale_cont #(
    parameter int AW      = 20,
    parameter int DW      = 24,
    parameter int FB_LOG2 = 8,
    parameter int NPH_W   = 2,
    parameter int PERIOD  = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [AW-1:0]    im_a,
    output logic             im_wen_n,
    output logic [DW-1:0]    im_d,
    input  logic [DW-1:0]    im_q,
    output logic [NPH_W-1:0] photo_idx,
    output logic             busy,
    output logic             frame_done
);

    localparam int CH  = DW / 3;
    localparam int ACW = CH + 2;
    localparam int CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int NW  = NPH_W + 1;

    typedef enum logic [1:0] {SETUP, HDR, COPY, HOLD} state_t;
    typedef enum logic [1:0] {M_UP, M_COPY, M_DOWN} mode_t;

    state_t              state;
    mode_t               mode;
    logic [2:0]          ph;
    logic [FB_LOG2-1:0]  x, y, nx, ny;
    logic [AW-1:0]       fb_addr, base;
    logic [NW-1:0]       n_photo, idx_inc;
    logic [NPH_W-1:0]    next_idx;
    logic [CW-1:0]       cnt;
    logic                period_end, last_px;
    logic [2:0]          rd_last, wr_ph;
    logic [2:0][ACW-1:0] acc, ch_sum;

    function automatic mode_t decode(input logic [1:0] code);
        case (code)
            2'b01:   return M_UP;
            2'b11:   return M_DOWN;
            default: return M_COPY;
        endcase
    endfunction

    function automatic logic [AW-1:0] hdr_addr(input logic [NPH_W-1:0] idx);
        return AW'(2) + (AW'(idx) << 1);
    endfunction

    // Source address for destination pixel (px,py); sub picks the 2x2 tap when downscaling.
    function automatic logic [AW-1:0] src_addr(input mode_t m, input logic [AW-1:0] b,
                                               input logic [FB_LOG2-1:0] px,
                                               input logic [FB_LOG2-1:0] py,
                                               input logic [1:0] sub);
        logic [AW-1:0] sx, sy, a;
        case (m)
            M_UP: begin
                sx = AW'(px >> 1);
                sy = AW'(py >> 1);
                a  = b + (sy << (FB_LOG2 - 1)) + sx;
            end
            M_DOWN: begin
                sx = (AW'(px) << 1) + AW'(sub[0]);
                sy = (AW'(py) << 1) + AW'(sub[1]);
                a  = b + (sy << (FB_LOG2 + 1)) + sx;
            end
            default: begin
                sx = AW'(px);
                sy = AW'(py);
                a  = b + (sy << FB_LOG2) + sx;
            end
        endcase
        return a;
    endfunction

    assign period_end = (cnt == CW'(PERIOD - 1));
    assign idx_inc    = NW'(photo_idx) + NW'(1);
    assign next_idx   = (idx_inc >= n_photo) ? '0 : idx_inc[NPH_W-1:0];
    assign rd_last    = (mode == M_DOWN) ? 3'd3 : 3'd0;
    assign wr_ph      = rd_last + 3'd1;
    assign last_px    = (x == '1) && (y == '1);
    assign nx         = x + 1'b1;
    assign ny         = (x == '1) ? y + 1'b1 : y;
    assign busy       = (state == COPY);

    always_comb begin
        for (int c = 0; c < 3; c++)
            ch_sum[c] = acc[c] + ACW'(im_q[c*CH +: CH]);
    end

    // NOTE: im_d follows im_q combinationally so one read and its write fit in two cycles;
    // the '0 default first also keeps this block free of inferred latches.
    always_comb begin
        im_d = '0;
        if (!im_wen_n) begin
            if (mode == M_DOWN) begin
                for (int c = 0; c < 3; c++)
                    im_d[c*CH +: CH] = ch_sum[c][ACW-1:2];
            end else begin
                im_d = im_q;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SETUP;
            mode       <= M_COPY;
            ph         <= '0;
            x          <= '0;
            y          <= '0;
            fb_addr    <= '0;
            base       <= '0;
            n_photo    <= '0;
            cnt        <= '0;
            im_a       <= '0;
            im_wen_n   <= 1'b1;
            photo_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= period_end ? '0 : cnt + 1'b1;
            im_wen_n   <= 1'b1;
            frame_done <= 1'b0;
            if (period_end && state != SETUP) begin
                state     <= HDR;
                ph        <= '0;
                photo_idx <= next_idx;
                im_a      <= hdr_addr(next_idx);
            end else begin
                case (state)
                    SETUP: begin
                        case (ph)
                            3'd0: begin
                                ph   <= 3'd1;
                                im_a <= AW'(1);
                            end
                            3'd1: begin
                                fb_addr <= AW'(im_q);
                                ph      <= 3'd2;
                            end
                            default: begin
                                n_photo <= (im_q[NW-1:0] == '0) ? NW'(1) : im_q[NW-1:0];
                                state   <= HDR;
                                ph      <= '0;
                                im_a    <= hdr_addr(photo_idx);
                            end
                        endcase
                    end
                    HDR: begin
                        case (ph)
                            3'd0: begin
                                ph   <= 3'd1;
                                im_a <= hdr_addr(photo_idx) + AW'(1);
                            end
                            3'd1: begin
                                base <= AW'(im_q);
                                ph   <= 3'd2;
                            end
                            default: begin
                                mode  <= decode(im_q[1:0]);
                                state <= COPY;
                                ph    <= '0;
                                x     <= '0;
                                y     <= '0;
                                im_a  <= src_addr(decode(im_q[1:0]), base, '0, '0, 2'd0);
                            end
                        endcase
                    end
                    COPY: begin
                        if (ph == wr_ph) begin
                            if (last_px) begin
                                state <= HOLD;
                                im_a  <= '0;
                            end else begin
                                x    <= nx;
                                y    <= ny;
                                ph   <= '0;
                                im_a <= src_addr(mode, base, nx, ny, 2'd0);
                            end
                        end else if (ph == rd_last) begin
                            ph         <= wr_ph;
                            im_a       <= fb_addr + AW'({y, x});
                            im_wen_n   <= 1'b0;
                            frame_done <= last_px;
                        end else begin
                            ph   <= ph + 3'd1;
                            im_a <= src_addr(mode, base, x, y, ph[1:0] + 2'd1);
                        end
                    end
                    HOLD: im_a <= '0;
                endcase
            end
        end
    end

    // Channel sums of the first three downscale taps; the fourth is added in im_d.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (state == COPY && mode == M_DOWN) begin
            if (ph == 3'd1) begin
                for (int c = 0; c < 3; c++)
                    acc[c] <= ACW'(im_q[c*CH +: CH]);
            end else if (ph == 3'd2 || ph == 3'd3) begin
                acc <= ch_sum;
            end
        end
    end

endmodule

// File: tb/tb_dpa_scale_cont.sv
// Bench for dpa_scale_cont: two instances (PERIOD 200 and 20) on small memory models,
// a per-cycle write scoreboard fed by a pixel-level model, plus literal spot checks.
module tb_dpa_scale_cont;

    localparam int AW = 12, DW = 24, FB_LOG2 = 2, NPH_W = 2, FB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_a, reset_b;
    logic [AW-1:0]    a_a, a_b;
    logic             wen_a, wen_b, busy_a, busy_b, fd_a, fd_b;
    logic [DW-1:0]    d_a, d_b, q_a, q_b;
    logic [NPH_W-1:0] idx_a, idx_b;

    dpa_scale_cont #(.AW(AW), .DW(DW), .FB_LOG2(FB_LOG2), .NPH_W(NPH_W), .PERIOD(200)) dut (
        .clk(clk), .reset(reset_a), .im_a(a_a), .im_wen_n(wen_a), .im_d(d_a), .im_q(q_a),
        .photo_idx(idx_a), .busy(busy_a), .frame_done(fd_a));

    dpa_scale_cont #(.AW(AW), .DW(DW), .FB_LOG2(FB_LOG2), .NPH_W(NPH_W), .PERIOD(20)) dut_ab (
        .clk(clk), .reset(reset_b), .im_a(a_b), .im_wen_n(wen_b), .im_d(d_b), .im_q(q_b),
        .photo_idx(idx_b), .busy(busy_b), .frame_done(fd_b));

    logic [DW-1:0] mem_a [0:4095];
    logic [DW-1:0] mem_b [0:4095];
    logic [DW-1:0] model_mem [0:4095];
    logic          ld_en;
    logic [AW-1:0] ld_a;
    logic [DW-1:0] ld_d;

    always @(posedge clk) begin
        if (ld_en) mem_a[ld_a] <= ld_d;
        else if (!wen_a) mem_a[a_a] <= d_a;
        q_a <= mem_a[a_a];
    end

    always @(posedge clk) begin
        if (ld_en) mem_b[ld_a] <= ld_d;
        else if (!wen_b) mem_b[a_b] <= d_b;
        q_b <= mem_b[a_b];
    end

    logic [AW-1:0] exp_a [0:255];
    logic [DW-1:0] exp_d [0:255];
    logic          exp_l [0:255];
    int exp_n = 0, rd_ptr = 0;
    int n_chk = 0, n_bad = 0;
    int dq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input int a, input logic [DW-1:0] d);
        ld_a = AW'(a);
        ld_d = d;
        ld_en = 1'b1;
        model_mem[a] = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Expected framebuffer writes of one photo, straight from the pixel rules.
    task automatic add_frame(input int fb, input int base, input int code);
        logic [DW-1:0] v;
        int s;
        for (int y = 0; y < FB; y++) begin
            for (int x = 0; x < FB; x++) begin
                if (code == 3) begin
                    for (int c = 0; c < 3; c++) begin
                        s = 0;
                        for (int dy = 0; dy < 2; dy++)
                            for (int dx = 0; dx < 2; dx++)
                                s += int'(model_mem[base + (2*y+dy)*(2*FB) + 2*x+dx][c*8 +: 8]);
                        v[c*8 +: 8] = 8'(s / 4);
                    end
                end else if (code == 1) begin
                    v = model_mem[base + (y/2)*(FB/2) + x/2];
                end else begin
                    v = model_mem[base + y*FB + x];
                end
                exp_a[exp_n] = AW'(fb + y*FB + x);
                exp_d[exp_n] = v;
                exp_l[exp_n] = (x == FB-1) && (y == FB-1);
                exp_n++;
            end
        end
    endtask

    task automatic single_photo(input int base, input int code, input int busy_req);
        int nb, nf, last;
        reset_a = 1'b1;
        exp_n = 0;
        load(0, 24'h800); load(1, 24'd1); load(2, DW'(base)); load(3, DW'(code));
        add_frame('h800, base, code);
        check("rst_im_a", a_a, 0);
        check("rst_wen_n", wen_a, 1);
        check("rst_im_d", d_a, 0);
        check("rst_idx", idx_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", fd_a, 0);
        reset_a = 1'b0;
        dq.delete();
        last = -1;
        for (int t = 0; t < 6; t++) begin
            if (t > 0) tick();
            if (int'(a_a) != last) dq.push_back(int'(a_a));
            last = int'(a_a);
            check("setup_wen_n", wen_a, 1);
            check("setup_idx", idx_a, 0);
        end
        check("setup_seq_len", dq.size(), 4);
        for (int i = 0; i < 4 && i < dq.size(); i++) check("setup_seq", dq[i], i);
        nb = 0;
        nf = 0;
        repeat (150) begin
            tick();
            if (busy_a) nb++;
            if (fd_a) nf++;
        end
        check("busy_cycles", nb, busy_req);
        check("frame_done_cnt", nf, 1);
        check("all_writes", rd_ptr, exp_n);
    endtask

    initial begin
        logic [DW-1:0] v;
        int nw, nf, n_rd;
        logic [AW-1:0] first_a;
        logic [DW-1:0] first_d;

        reset_a = 1'b1;
        reset_b = 1'b1;
        ld_en = 1'b0;
        ld_a = '0;
        ld_d = '0;

        fork
            forever begin
                tick();
                if (reset_a) begin
                    rd_ptr = 0;
                end else if (!wen_a) begin
                    check("wr_busy", busy_a, 1);
                    check("wr_expected", rd_ptr < exp_n, 1);
                    if (rd_ptr < exp_n) begin
                        check("wr_addr", a_a, exp_a[rd_ptr]);
                        check("wr_data", d_a, exp_d[rd_ptr]);
                        check("wr_done", fd_a, exp_l[rd_ptr]);
                        rd_ptr++;
                    end
                end else begin
                    check("done_idle", fd_a, 0);
                end
            end
        join_none

        tick();
        tick();
        for (int i = 0; i < 16; i++) load('h100 + i, 24'hA0B000 + DW'(i));
        load('h200, 24'h111111); load('h201, 24'h222222);
        load('h202, 24'h333333); load('h203, 24'h444444);
        for (int i = 0; i < 64; i++) begin
            v = {8'(i*5 + 1), 8'(i*3 + 2), 8'(i*7)};
            if (i == 0) v = 24'h040404;
            if (i == 1) v = 24'h080808;
            if (i == 8) v = 24'h0C0C0C;
            if (i == 9) v = 24'h101013;
            load('h300 + i, v);
        end

        // Copy, upscale and downscale, one photo each.
        single_photo('h100, 2, 32);
        check("copy_px5", mem_a['h805], 24'hA0B005);
        check("copy_px15", mem_a['h80F], 24'hA0B00F);
        single_photo('h200, 1, 32);
        check("up_3_3", mem_a['h80F], 24'h444444);
        check("up_1_2", mem_a['h809], 24'h333333);
        single_photo('h300, 3, 80);
        check("down_0_0", mem_a['h800], 24'h0A0A0A);

        // Rotation through three photos.
        reset_a = 1'b1;
        exp_n = 0;
        load(0, 24'h800); load(1, 24'd3);
        load(2, 24'h100); load(3, 24'd2);
        load(4, 24'h200); load(5, 24'd1);
        load(6, 24'h300); load(7, 24'd3);
        add_frame('h800, 'h100, 2);
        add_frame('h800, 'h200, 1);
        add_frame('h800, 'h300, 3);
        add_frame('h800, 'h100, 2);
        reset_a = 1'b0;
        nf = 0;
        for (int t = 1; t <= 640; t++) begin
            tick();
            if (fd_a) nf++;
            case (t)
                199: check("rot_idx_199", idx_a, 0);
                200: begin check("rot_idx_200", idx_a, 1); check("rot_a_200", a_a, 4); end
                201: check("rot_a_201", a_a, 5);
                399: check("rot_idx_399", idx_a, 1);
                400: begin check("rot_idx_400", idx_a, 2); check("rot_a_400", a_a, 6); end
                401: check("rot_a_401", a_a, 7);
                599: check("rot_idx_599", idx_a, 2);
                600: begin check("rot_idx_600", idx_a, 0); check("rot_a_600", a_a, 2); end
                601: check("rot_a_601", a_a, 3);
                default: ;
            endcase
        end
        check("rot_frames", nf, 4);
        check("rot_all_writes", rd_ptr, exp_n);

        // Period expiry in the middle of a downscale (second instance).
        reset_a = 1'b1;
        exp_n = 0;
        load(0, 24'h800); load(1, 24'd2);
        load(2, 24'h300); load(3, 24'd3);
        load(4, 24'h100); load(5, 24'd2);
        reset_b = 1'b0;
        nw = 0;
        nf = 0;
        first_a = '0;
        first_d = '0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 19) check("abort_busy_19", busy_b, 1);
            if (t < 20) begin
                if (!wen_b) begin
                    if (nw == 0) begin
                        first_a = a_b;
                        first_d = d_b;
                    end
                    nw++;
                end
                if (fd_b) nf++;
            end
        end
        check("abort_wr_max3", nw <= 3, 1);
        check("abort_wr_min1", nw >= 1, 1);
        check("abort_first_a", first_a, 'h800);
        check("abort_first_d", first_d, 24'h0A0A0A);
        check("abort_no_done", nf, 0);
        check("abort_idx", idx_b, 1);
        check("abort_hdr_a", a_b, 4);
        check("abort_wen_n", wen_b, 1);
        check("abort_busy", busy_b, 0);
        reset_b = 1'b1;

        // Reset asserted during a write cycle.
        load(0, 24'h800); load(1, 24'd1); load(2, 24'h100); load(3, 24'd2);
        add_frame('h800, 'h100, 2);
        reset_a = 1'b0;
        nw = 0;
        n_rd = 0;
        while (nw < 3 && n_rd < 60) begin
            tick();
            n_rd++;
            if (!wen_a) nw++;
        end
        check("midwr_reached", nw, 3);
        reset_a = 1'b1;
        tick();
        check("midwr_im_a", a_a, 0);
        check("midwr_wen_n", wen_a, 1);
        check("midwr_im_d", d_a, 0);
        check("midwr_idx", idx_a, 0);
        check("midwr_busy", busy_a, 0);
        check("midwr_done", fd_a, 0);
        tick();
        check("midwr_wen_n_2", wen_a, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
